cause_encoder_8val: RTL and testbench

Registered 8-to-3 priority encoder with sticky pending capture and a valid/ack handoff. It collects up to eight single-bit event sources (exception/stall causes) into a pending register and presents the highest-priority enabled cause as a 3-bit index. It holds that index stable until the consumer acknowledges it. It is the encode-side counterpart of the 3-to-8 select decoder in the pipeline control path.

---
 rtl/cause_encoder_8val_if.sv | 21 ++
 rtl/cause_encoder_8val.sv | 108 ++++++++++
 tb/tb_cause_encoder_8val.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cause_encoder_8val_if.sv
// Handoff bundle between event producers, the cause encoder and its consumer.
// The master side drives requests, enables and acknowledge; the slave side offers causes.
interface cause_encoder_8val_if;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ack;
   logic       valid;
   logic [2:0] index;
   logic [7:0] pending;
   logic [7:0] overrun;

   modport master (
      output req, mask, ack,
      input  valid, index, pending, overrun
   );

   modport slave (
      input  req, mask, ack,
      output valid, index, pending, overrun
   );
endinterface

// File: rtl/cause_encoder_8val.sv
// Registered 8-to-3 priority encoder with sticky pending capture and a
// valid/ack handoff that freezes the offered index until it is accepted.
module cause_encoder_8val #(
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   cause_encoder_8val_if.slave  bus
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t     state_q, state_d;
   logic [2:0] index_q, index_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] overrun_q, overrun_d;
   logic [7:0] elig;
   logic [7:0] clr;
   logic [2:0] enc_idx;
   logic       take;

   assign take = (state_q == OFFER) && bus.ack;
   assign elig = pending_q & bus.mask;

   always_comb begin
      clr = '0;
      if (take) begin
         clr[index_q] = 1'b1;
      end
   end

   // Set wins over clear, so a request landing on the acked bit stays pending.
   assign pending_d = (pending_q & ~clr) | bus.req;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_overrun
         always_comb begin
            overrun_d[gi] = overrun_q[gi];
            if (bus.req[gi] && pending_q[gi] && !clr[gi]) begin
               overrun_d[gi] = 1'b1;
            end else if (clr[gi] && !bus.req[gi]) begin
               overrun_d[gi] = 1'b0;
            end
         end
      end
   endgenerate

   generate
      if (LOW_FIRST) begin : g_enc_low
         always_comb begin
            enc_idx = '0;
            for (int i = 7; i >= 0; i--) begin
               if (elig[i]) begin
                  enc_idx = 3'(i);
               end
            end
         end
      end else begin : g_enc_high
         always_comb begin
            enc_idx = '0;
            for (int i = 0; i < 8; i++) begin
               if (elig[i]) begin
                  enc_idx = 3'(i);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      unique case (state_q)
         IDLE: begin
            if (elig != 8'h00) begin
               index_d = enc_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (bus.ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         index_q   <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.valid   = (state_q == OFFER);
   assign bus.index   = index_q;
   assign bus.pending = pending_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cause_encoder_8val.sv
// Directed bench for cause_encoder_8val: one instance per priority direction,
// inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_cause_encoder_8val;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   cause_encoder_8val_if bus_a ();
   cause_encoder_8val_if bus_b ();

   cause_encoder_8val #(.LOW_FIRST(1'b1)) dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));
   cause_encoder_8val #(.LOW_FIRST(1'b0)) dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("reset: a valid=%0b idx=%0d pend=%h ovr=%h", bus_a.valid, bus_a.index, bus_a.pending, bus_a.overrun);
      n_cmp++; if (bus_a.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", bus_a.valid); end
      n_cmp++; if (bus_a.index !== 3'd0) begin n_fail++; $display("FAIL reset_index_a: got %0d want 0", bus_a.index); end
      n_cmp++; if (bus_a.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending_a: got %h want 00", bus_a.pending); end
      n_cmp++; if (bus_a.overrun !== 8'h00) begin n_fail++; $display("FAIL reset_overrun_a: got %h want 00", bus_a.overrun); end
      n_cmp++; if (bus_b.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", bus_b.valid); end
      n_cmp++; if (bus_b.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending_b: got %h want 00", bus_b.pending); end
   endtask

   task automatic test_reset_mid_offer();
      bus_a.req = 8'h10;
      step();
      bus_a.req = 8'h00;
      step();
      $display("mid-offer: valid=%0b idx=%0d", bus_a.valid, bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd4) begin n_fail++; $display("FAIL midrst_offer: got v=%b i=%0d want v=1 i=4", bus_a.valid, bus_a.index); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("after reset: valid=%0b idx=%0d pend=%h ovr=%h", bus_a.valid, bus_a.index, bus_a.pending, bus_a.overrun);
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.index !== 3'd0) begin n_fail++; $display("FAIL midrst_clear: got v=%b i=%0d want v=0 i=0", bus_a.valid, bus_a.index); end
      n_cmp++; if (bus_a.pending !== 8'h00 || bus_a.overrun !== 8'h00) begin n_fail++; $display("FAIL midrst_regs: got p=%h o=%h want 00/00", bus_a.pending, bus_a.overrun); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus_a.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_offer: cycle %0d got valid=%b want 0", i, bus_a.valid); end
      end
   endtask

   task automatic test_priority_low();
      bus_a.req = 8'hA4;
      step();
      bus_a.req = 8'h00;
      n_cmp++; if (bus_a.pending !== 8'hA4 || bus_a.valid !== 1'b0) begin n_fail++; $display("FAIL low_capture: got p=%h v=%b want A4/0", bus_a.pending, bus_a.valid); end
      step();
      $display("low: offer idx=%0d", bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd2) begin n_fail++; $display("FAIL low_first: got v=%b i=%0d want 1/2", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'hA0) begin n_fail++; $display("FAIL low_ack1: got v=%b p=%h want 0/A0", bus_a.valid, bus_a.pending); end
      step();
      $display("low: offer idx=%0d", bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd5) begin n_fail++; $display("FAIL low_second: got v=%b i=%0d want 1/5", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'h80) begin n_fail++; $display("FAIL low_ack2: got v=%b p=%h want 0/80", bus_a.valid, bus_a.pending); end
      step();
      $display("low: offer idx=%0d", bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd7) begin n_fail++; $display("FAIL low_third: got v=%b i=%0d want 1/7", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
      step();
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'h00) begin n_fail++; $display("FAIL low_drain: got v=%b p=%h want 0/00", bus_a.valid, bus_a.pending); end
   endtask

   task automatic test_priority_high();
      bus_b.req = 8'hA4;
      step();
      bus_b.req = 8'h00;
      step();
      $display("high: offer idx=%0d", bus_b.index);
      n_cmp++; if (bus_b.valid !== 1'b1 || bus_b.index !== 3'd7) begin n_fail++; $display("FAIL high_first: got v=%b i=%0d want 1/7", bus_b.valid, bus_b.index); end
      bus_b.ack = 1'b1;
      step();
      bus_b.ack = 1'b0;
      n_cmp++; if (bus_b.valid !== 1'b0 || bus_b.pending !== 8'h24) begin n_fail++; $display("FAIL high_ack1: got v=%b p=%h want 0/24", bus_b.valid, bus_b.pending); end
      step();
      $display("high: offer idx=%0d", bus_b.index);
      n_cmp++; if (bus_b.valid !== 1'b1 || bus_b.index !== 3'd5) begin n_fail++; $display("FAIL high_second: got v=%b i=%0d want 1/5", bus_b.valid, bus_b.index); end
      bus_b.ack = 1'b1;
      step();
      bus_b.ack = 1'b0;
      n_cmp++; if (bus_b.pending !== 8'h04) begin n_fail++; $display("FAIL high_ack2: got p=%h want 04", bus_b.pending); end
      step();
      $display("high: offer idx=%0d", bus_b.index);
      n_cmp++; if (bus_b.valid !== 1'b1 || bus_b.index !== 3'd2) begin n_fail++; $display("FAIL high_third: got v=%b i=%0d want 1/2", bus_b.valid, bus_b.index); end
      bus_b.ack = 1'b1;
      step();
      bus_b.ack = 1'b0;
      n_cmp++; if (bus_b.valid !== 1'b0 || bus_b.pending !== 8'h00) begin n_fail++; $display("FAIL high_drain: got v=%b p=%h want 0/00", bus_b.valid, bus_b.pending); end
   endtask

   task automatic test_frozen_offer();
      bus_a.req = 8'h08;
      step();
      bus_a.req = 8'h00;
      step();
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd3) begin n_fail++; $display("FAIL frz_offer: got v=%b i=%0d want 1/3", bus_a.valid, bus_a.index); end
      bus_a.req  = 8'h01;
      bus_a.mask = 8'h00;
      step();
      bus_a.req = 8'h00;
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd3 || bus_a.pending !== 8'h09) begin n_fail++; $display("FAIL frz_hold1: got v=%b i=%0d p=%h want 1/3/09", bus_a.valid, bus_a.index, bus_a.pending); end
      step();
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd3) begin n_fail++; $display("FAIL frz_hold2: got v=%b i=%0d want 1/3", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
      $display("frozen: acked idx=3 pend=%h", bus_a.pending);
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'h01) begin n_fail++; $display("FAIL frz_ack: got v=%b p=%h want 0/01", bus_a.valid, bus_a.pending); end
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if (bus_a.valid !== 1'b0) begin n_fail++; $display("FAIL frz_masked: cycle %0d got valid=%b want 0", i, bus_a.valid); end
      end
      bus_a.mask = 8'h01;
      step();
      step();
      $display("frozen: unmasked offer idx=%0d", bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd0) begin n_fail++; $display("FAIL frz_unmask: got v=%b i=%0d want 1/0", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack  = 1'b0;
      bus_a.mask = 8'hFF;
      n_cmp++; if (bus_a.pending !== 8'h00) begin n_fail++; $display("FAIL frz_drain: got p=%h want 00", bus_a.pending); end
   endtask

   task automatic test_set_wins_overrun();
      bus_a.req = 8'h02;
      step();
      bus_a.req = 8'h00;
      step();
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd1) begin n_fail++; $display("FAIL sw_offer: got v=%b i=%0d want 1/1", bus_a.valid, bus_a.index); end
      bus_a.req = 8'h02;
      bus_a.ack = 1'b1;
      step();
      bus_a.req = 8'h00;
      bus_a.ack = 1'b0;
      $display("set-wins: pend=%h ovr=%h", bus_a.pending, bus_a.overrun);
      n_cmp++; if (bus_a.pending !== 8'h02 || bus_a.overrun !== 8'h00) begin n_fail++; $display("FAIL sw_set_wins: got p=%h o=%h want 02/00", bus_a.pending, bus_a.overrun); end
      step();
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd1) begin n_fail++; $display("FAIL sw_reoffer: got v=%b i=%0d want 1/1", bus_a.valid, bus_a.index); end
      bus_a.req = 8'h02;
      step();
      bus_a.req = 8'h00;
      $display("overrun: ovr=%h", bus_a.overrun);
      n_cmp++; if (bus_a.overrun !== 8'h02 || bus_a.valid !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got o=%h v=%b want 02/1", bus_a.overrun, bus_a.valid); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
      n_cmp++; if (bus_a.overrun !== 8'h00 || bus_a.pending !== 8'h00) begin n_fail++; $display("FAIL ovr_clear: got o=%h p=%h want 00/00", bus_a.overrun, bus_a.pending); end
   endtask

   task automatic test_ack_idle();
      step();
      bus_a.ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'h00 || bus_a.overrun !== 8'h00) begin n_fail++; $display("FAIL idle_ack: cycle %0d got v=%b p=%h o=%h want 0/00/00", i, bus_a.valid, bus_a.pending, bus_a.overrun); end
      end
      bus_a.ack = 1'b0;
      bus_a.req = 8'h40;
      step();
      bus_a.req = 8'h00;
      n_cmp++; if (bus_a.valid !== 1'b0 || bus_a.pending !== 8'h40) begin n_fail++; $display("FAIL idle_capture: got v=%b p=%h want 0/40", bus_a.valid, bus_a.pending); end
      step();
      $display("ack-idle: offer idx=%0d", bus_a.index);
      n_cmp++; if (bus_a.valid !== 1'b1 || bus_a.index !== 3'd6) begin n_fail++; $display("FAIL idle_offer: got v=%b i=%0d want 1/6", bus_a.valid, bus_a.index); end
      bus_a.ack = 1'b1;
      step();
      bus_a.ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.req  = 8'h00;
      bus_a.mask = 8'hFF;
      bus_a.ack  = 1'b0;
      bus_b.req  = 8'h00;
      bus_b.mask = 8'hFF;
      bus_b.ack  = 1'b0;
      #1;
      test_reset();
      test_reset_mid_offer();
      test_priority_low();
      test_priority_high();
      test_frozen_offer();
      test_set_wins_overrun();
      test_ack_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
